// File: rtl/lfsr_victim_sel.sv
// Galois LFSR with cache/TLB replacement-victim picker (lowest invalid way, else pseudo-random way).
// Optional zero-state recovery enabled by defining LFSR_LOCKUP_RECOVER_EN.
module lfsr_victim_sel #(
  parameter int                WIDTH    = 8,
  parameter logic [WIDTH-1:0]  TAPS     = 8'h71,
  parameter logic [WIDTH-1:0]  SEED     = 8'hFF,
  parameter int                NUM_WAYS = 4,
  localparam int               IDX_W    = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_en,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic                 pick_req,
  input  logic [NUM_WAYS-1:0]  valid_mask,
  output logic [WIDTH-1:0]     rand_o,
  output logic                 pick_valid,
  output logic [IDX_W-1:0]     pick_idx,
  output logic                 lockup
);

  // Truncated way count: zero for power-of-two NUM_WAYS, so the wrap below becomes a no-op.
  localparam logic [IDX_W-1:0] NW_WRAP = IDX_W'(NUM_WAYS);

  logic [WIDTH-1:0] rand_q, rand_d;
  logic [WIDTH-1:0] step_val;
  logic             pick_valid_q;
  logic [IDX_W-1:0] pick_idx_q;
  logic [IDX_W-1:0] low_zero;
  logic [IDX_W-1:0] rnd_r;
  logic [IDX_W-1:0] rnd_idx;
  logic [IDX_W-1:0] victim;

  always_comb begin
    step_val = {rand_q[WIDTH-2:0], 1'b0} ^ (rand_q[WIDTH-1] ? TAPS : '0);
  end

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic lockup_q, lockup_d;
`endif

  always_comb begin
    rand_d = rand_q;
`ifdef LFSR_LOCKUP_RECOVER_EN
    lockup_d = 1'b0;
`endif
    if (load) begin
      rand_d = load_val;
    end
`ifdef LFSR_LOCKUP_RECOVER_EN
    else if (rand_q == '0) begin
      rand_d   = SEED;
      lockup_d = 1'b1;
    end
`endif
    else if (step_en || pick_req) begin
      rand_d = step_val;
    end
  end

  // Scan from the top so the lowest zero bit is the last one written.
  always_comb begin
    low_zero = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid_mask[i]) low_zero = IDX_W'(i);
    end
    rnd_r   = rand_q[IDX_W-1:0];
    rnd_idx = (rnd_r >= NW_WRAP) ? rnd_r - NW_WRAP : rnd_r;
    victim  = (&valid_mask) ? rnd_idx : low_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rand_q       <= SEED;
      pick_valid_q <= 1'b0;
      pick_idx_q   <= '0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      lockup_q     <= 1'b0;
`endif
    end else begin
      rand_q       <= rand_d;
      pick_valid_q <= pick_req;
      if (pick_req) pick_idx_q <= victim;
`ifdef LFSR_LOCKUP_RECOVER_EN
      lockup_q     <= lockup_d;
`endif
    end
  end

  assign rand_o     = rand_q;
  assign pick_valid = pick_valid_q;
  assign pick_idx   = pick_idx_q;
`ifdef LFSR_LOCKUP_RECOVER_EN
  assign lockup     = lockup_q;
`else
  assign lockup     = 1'b0;
`endif

endmodule

// File: doc/lfsr_victim_sel.md
Name: lfsr_victim_sel

Overview:
Parametrised Galois LFSR pseudo-random generator with an integrated replacement-victim picker for the TLB and set-associative caches. Width, polynomial, seed and way count are configurable, and the block supports run-time reseeding. A pick request returns the lowest invalid way when one exists; otherwise it returns a pseudo-random way bounded to NUM_WAYS. The block sits beside the cache/TLB refill controllers, one instance per structure.

Parameters:
WIDTH, 8, LFSR state width (at least 3).
TAPS, 8'h71, Galois feedback mask (bit i set means XOR msb into bit i). Default is x^8+x^6+x^5+x^4+1, which is maximal length.
SEED, 8'hFF, reset and recovery value. Must be non-zero.
NUM_WAYS, 4, number of ways, 2..2^(WIDTH-1).
IDX_W, derived clog2(NUM_WAYS), localparam, not overridable.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
step_en  in  1  advance LFSR this cycle
load  in  1  reseed request
load_val  in  WIDTH  reseed value
pick_req  in  1  victim pick request
valid_mask  in  NUM_WAYS  per-way valid bits, sampled with pick_req
rand  out  WIDTH  current LFSR state (registered)
pick_valid  out  1  one-cycle pulse: pick_idx valid
pick_idx  out  IDX_W  selected victim way (registered, held until next pick)
lockup  out  1  one-cycle pulse: zero-state recovery occurred

Behaviour:
- Reset (clk edge with rst=1):
  - rand=SEED, pick_valid=0, pick_idx=0, lockup=0.
  - rst has priority over all other inputs, including mid-pick.
- Step function: next = {rand[WIDTH-2:0],1'b0} ^ (rand[WIDTH-1] ? TAPS : 0).
- State update priority: rst > load > advance.
  - load=1: rand<=load_val. Any simultaneous step_en or pick_req does not advance the LFSR.
  - Otherwise, advance exactly once if step_en|pick_req. The state never advances twice in one cycle.
  - Otherwise hold.
- Pick, with one-cycle latency:
  - pick_req=1 at edge N samples valid_mask and the pre-update rand.
  - pick_valid=1 and pick_idx are updated at edge N+1. No stall and no ready signal; back-to-back picks are allowed, one result per cycle.
  - If valid_mask != all-ones: pick_idx = index of the lowest zero bit.
  - Else r = rand[IDX_W-1:0]; pick_idx = (r >= NUM_WAYS) ? r - NUM_WAYS : r. Only one subtraction is ever needed, because IDX_W = clog2.
  - NUM_WAYS a power of two: pick_idx = r.
  - A pick coinciding with load still completes, using the pre-load rand.
- pick_valid is 0 in every cycle that has no pick in the previous cycle.
- Zero state:
  - Only reachable via load_val=0; the LFSR never steps into zero from a non-zero state.
  - Behaviour in zero state is governed by the optional feature.
- Period: 2^WIDTH-1 steps for a primitive TAPS. With the defaults, 255.

Optional Feature:
LFSR_LOCKUP_RECOVER_EN
- Defined:
  - Any cycle in which rand==0 and no load/rst is present reloads rand<=SEED at the next edge.
  - lockup pulses 1 in the cycle after the reload edge.
  - A pick sampled while rand==0 still uses r=0.
- Not defined:
  - The zero state persists: stepping 0 yields 0.
  - lockup is tied to 0.

Test Plan:
- Reset, then step_en=1 for 2 cycles -> rand FF, 8F, 6F; 255 total steps return rand to FF.
- rand=8F, pick_req=1, valid_mask=4'b1011 -> next cycle pick_valid=1, pick_idx=2, rand=6F.
- rand=8F, pick_req=1, valid_mask=4'b1111 -> pick_idx=3. With NUM_WAYS=3 and the same rand -> pick_idx=0.
- load=1, load_val=8'h5A, with step_en=1 and pick_req=1 -> rand=5A (not stepped); pick uses the pre-load value.
- load_val=0 with the macro defined -> rand=00 for one cycle, then FF, lockup pulse. Without the macro -> rand stays 00 under step_en.
- rst asserted in the cycle after pick_req -> pick_valid=0, pick_idx=0, rand=FF.
